// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and defaults for the UART transmit arbiter:
//                arbiter state encoding, default requester count and
//                default inter-byte gap length.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Default number of requesters sharing the serial transmitter
    localparam int c_N_REQ_DEFAULT   = 3;
    // Default number of idle cycles between consecutive bytes
    localparam int c_GAP_CYC_DEFAULT = 1;

    // Arbiter states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_t;

    // Width of a requester index; never narrower than one bit
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_arb_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin winner search. The search starts
//                one position after the previous winner and wraps, so the
//                most recently served requester has the lowest priority.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import uart_pkg::*;
#(
    parameter int N_REQ = c_N_REQ_DEFAULT,
    parameter int IW    = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    last_w,
    output logic [IW-1:0]    winner,
    output logic             valid
);

    logic [IW-1:0] w_idx;

    // Walk offsets from farthest to nearest so the nearest active request wins
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        w_idx  = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            w_idx = IW'((int'(last_w) + k) % N_REQ);
            if (req[w_idx]) begin
                winner = w_idx;
                valid  = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arb.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arb
//  Description : Round-robin arbiter letting N_REQ requesters share one
//                serial transmitter through its send_data / Sdata_valid /
//                Send_fin handshake. One byte is in flight at a time; an
//                optional gap of GAP_CYC idle cycles separates bytes.
//                Optional feature macro: UART_TX_ARB_LOCK_EN - when defined,
//                a requester holding lock keeps the transmitter for
//                back-to-back bytes (burst hold).
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int N_REQ   = c_N_REQ_DEFAULT,
    parameter int GAP_CYC = c_GAP_CYC_DEFAULT
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [N_REQ-1:0]     req,
    input  logic [8*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]     lock,
    output logic [N_REQ-1:0]     gnt,
    output logic [N_REQ-1:0]     done,
    output logic [7:0]           send_data,
    output logic                 Sdata_valid,
    input  logic                 Send_fin,
    output logic                 busy
);

    localparam int               c_IW       = idx_width(N_REQ);
    localparam logic [N_REQ-1:0] c_ONE      = N_REQ'(1);
    localparam logic [c_IW-1:0]  c_LAST_RST = c_IW'(N_REQ - 1);
    localparam logic [3:0]       c_GAP_LOAD = (GAP_CYC > 0) ? 4'(GAP_CYC - 1) : 4'd0;

    arb_state_t       r_state;
    arb_state_t       w_state_next;
    logic [c_IW-1:0]  r_last_w;
    logic [7:0]       r_send_data;
    logic [N_REQ-1:0] r_gnt;
    logic [N_REQ-1:0] r_done;
    logic [3:0]       r_gap_cnt;

    logic [c_IW-1:0]  w_rr_win;
    logic             w_rr_valid;
    logic [c_IW-1:0]  w_win;
    logic             w_win_valid;
    logic             w_grant;
    logic             w_finish;

    rr_pick #(
        .N_REQ (N_REQ),
        .IW    (c_IW)
    ) u_rr_pick (
        .req    (req),
        .last_w (r_last_w),
        .winner (w_rr_win),
        .valid  (w_rr_valid)
    );

`ifdef UART_TX_ARB_LOCK_EN
    logic r_have_owner;
    logic w_hold;

    // A locked, still-requesting previous winner overrides round-robin
    always_comb begin
        w_hold      = r_have_owner & lock[r_last_w] & req[r_last_w];
        w_win       = w_hold ? r_last_w : w_rr_win;
        w_win_valid = w_hold | w_rr_valid;
    end

    // Tracks whether last_w names a real previous grant (not the reset value)
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_have_owner <= 1'b0;
        end else if (w_grant) begin
            r_have_owner <= 1'b1;
        end
    end
`else
    logic w_unused_lock;

    // Burst hold is compiled out; lock is accepted but has no effect
    always_comb begin
        w_win         = w_rr_win;
        w_win_valid   = w_rr_valid;
        w_unused_lock = ^lock;
    end
`endif

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; Send_fin only has meaning while a byte is in flight
    always_comb begin
        w_state_next = r_state;
        w_grant      = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_win_valid) begin
                    w_state_next = ST_SEND;
                    w_grant      = 1'b1;
                end
            end
            ST_SEND: begin
                if (Send_fin) begin
                    w_finish     = 1'b1;
                    w_state_next = (GAP_CYC == 0) ? ST_IDLE : ST_GAP;
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == 4'd0) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Grant/done pulses, winner history, byte latch and gap counter
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_last_w    <= c_LAST_RST;
            r_send_data <= 8'd0;
            r_gnt       <= '0;
            r_done      <= '0;
            r_gap_cnt   <= 4'd0;
        end else begin
            r_gnt  <= '0;
            r_done <= '0;
            if (w_grant) begin
                r_gnt       <= c_ONE << w_win;
                r_last_w    <= w_win;
                r_send_data <= req_data[{w_win, 3'b000} +: 8];
            end
            if (w_finish) begin
                r_done    <= c_ONE << r_last_w;
                r_gap_cnt <= c_GAP_LOAD;
            end else if ((r_state == ST_GAP) && (r_gap_cnt != 4'd0)) begin
                r_gap_cnt <= r_gap_cnt - 4'd1;
            end
        end
    end

    assign gnt         = r_gnt;
    assign done        = r_done;
    assign send_data   = r_send_data;
    assign Sdata_valid = (r_state == ST_SEND);
    assign busy        = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_arb
//  Description : Self-checking bench for uart_tx_arb. Directed stimulus
//                pushes expected grants/completions into queues; a monitor
//                pops and compares whenever gnt or done pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arb;

    localparam int N   = 3;
    localparam int GAP = 1;

    logic           CLK = 1'b0;
    logic           RST;
    logic [N-1:0]   req;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   lock;
    logic [N-1:0]   gnt;
    logic [N-1:0]   done;
    logic [7:0]     send_data;
    logic           Sdata_valid;
    logic           Send_fin;
    logic           busy;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int         idx;
        logic [7:0] data;
    } exp_t;

    exp_t       gnt_q[$];
    exp_t       done_q[$];
    exp_t       mon_e;
    logic [7:0] cur_data = 8'd0;

    uart_tx_arb #(
        .N_REQ   (N),
        .GAP_CYC (GAP)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .req         (req),
        .req_data    (req_data),
        .lock        (lock),
        .gnt         (gnt),
        .done        (done),
        .send_data   (send_data),
        .Sdata_valid (Sdata_valid),
        .Send_fin    (Send_fin),
        .busy        (busy)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic push_exp(input int idx, input logic [7:0] data, input bit with_done);
        exp_t e;
        e.idx  = idx;
        e.data = data;
        gnt_q.push_back(e);
        if (with_done) done_q.push_back(e);
    endtask

    task automatic do_reset();
        req      = '0;
        lock     = '0;
        Send_fin = 1'b0;
        RST      = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    task automatic wait_gnt(output int cyc);
        cyc = 0;
        do begin
            @(posedge CLK);
            #1;
            cyc++;
        end while (gnt == '0 && cyc < 60);
        if (gnt == '0) begin
            n_checks++;
            n_errors++;
            $display("FAIL gnt_timeout: no grant within %0d cycles, required a grant", cyc);
        end
    endtask

    task automatic pulse_fin(input int wait_cyc);
        repeat (wait_cyc) begin
            @(posedge CLK);
            #1;
        end
        Send_fin = 1'b1;
        @(posedge CLK);
        #1;
        Send_fin = 1'b0;
    endtask

    // Monitor: every grant and completion must match the next expected entry
    always @(negedge CLK) begin
        if (!RST) begin
            if (gnt != '0) begin
                n_checks++;
                if (gnt_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_gnt: actual gnt=%b, required none", gnt);
                end else begin
                    mon_e = gnt_q.pop_front();
                    cur_data = mon_e.data;
                    if (gnt !== onehot(mon_e.idx) || send_data !== mon_e.data || Sdata_valid !== 1'b1) begin
                        n_errors++;
                        $display("FAIL gnt_match: actual gnt=%b data=%h valid=%b, required gnt=%b data=%h valid=1",
                                 gnt, send_data, Sdata_valid, onehot(mon_e.idx), mon_e.data);
                    end
                end
            end
            if (done != '0) begin
                n_checks++;
                if (done_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_done: actual done=%b, required none", done);
                end else begin
                    mon_e = done_q.pop_front();
                    if (done !== onehot(mon_e.idx) || gnt !== '0 || Sdata_valid !== 1'b0) begin
                        n_errors++;
                        $display("FAIL done_match: actual done=%b gnt=%b valid=%b, required done=%b gnt=0 valid=0",
                                 done, gnt, Sdata_valid, onehot(mon_e.idx));
                    end
                end
            end
            if (Sdata_valid) begin
                n_checks++;
                if (send_data !== cur_data || busy !== 1'b1) begin
                    n_errors++;
                    $display("FAIL send_stable: actual data=%h busy=%b, required data=%h busy=1",
                             send_data, busy, cur_data);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        int gap;
        int guard;

        req      = '0;
        req_data = '0;
        lock     = '0;
        Send_fin = 1'b0;
        RST      = 1'b1;

        // Reset state
        do_reset();
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_send_data", 32'(send_data), 0);
        chk("rst_valid", 32'(Sdata_valid), 0);
        chk("rst_busy", 32'(busy), 0);

        // Scenario 1: single byte from requester 0
        req_data = {8'h00, 8'h00, 8'h99};
        req      = 3'b001;
        push_exp(0, 8'h99, 1'b1);
        wait_gnt(cyc);
        chk("s1_gnt_latency", 32'(cyc), 1);
        chk("s1_busy", 32'(busy), 1);
        req = '0;
        pulse_fin(10);
        chk("s1_done", 32'(done), 32'b001);
        chk("s1_valid_drop", 32'(Sdata_valid), 0);

        // Scenario 3: Send_fin during GAP, then during IDLE
        Send_fin = 1'b1;
        @(posedge CLK);
        #1;
        Send_fin = 1'b0;
        chk("s3_gap_fin_busy", 32'(busy), 0);
        chk("s3_gap_fin_done", 32'(done), 0);
        chk("s3_gap_fin_valid", 32'(Sdata_valid), 0);
        Send_fin = 1'b1;
        @(posedge CLK);
        #1;
        Send_fin = 1'b0;
        chk("s3_idle_fin_busy", 32'(busy), 0);
        chk("s3_idle_fin_done", 32'(done), 0);
        chk("s3_idle_fin_valid", 32'(Sdata_valid), 0);

        // Scenario 2: three requesters held, round-robin order 0,1,2,0
        do_reset();
        req_data = {8'h33, 8'h22, 8'h11};
        req      = 3'b111;
        push_exp(0, 8'h11, 1'b1);
        push_exp(1, 8'h22, 1'b1);
        push_exp(2, 8'h33, 1'b1);
        push_exp(0, 8'h11, 1'b1);
        wait_gnt(cyc);
        for (int b = 0; b < 4; b++) begin
            pulse_fin(10);
            if (b == 3) begin
                req = '0;
            end else begin
                gap   = 0;
                guard = 0;
                while (gnt == '0 && guard < 40) begin
                    if (busy && !Sdata_valid) gap++;
                    @(posedge CLK);
                    #1;
                    guard++;
                end
                chk($sformatf("s2_gap%0d", b), 32'(gap), 32'(GAP));
            end
        end
        repeat (4) @(posedge CLK);
        #1;

        // Scenario 4: reset three cycles into SEND abandons the byte
        do_reset();
        req_data = {8'hC3, 8'hB2, 8'hA1};
        req      = 3'b010;
        push_exp(1, 8'hB2, 1'b0);
        wait_gnt(cyc);
        req = '0;
        repeat (3) begin
            @(posedge CLK);
            #1;
        end
        RST = 1'b1;
        @(posedge CLK);
        #1;
        chk("s4_valid", 32'(Sdata_valid), 0);
        chk("s4_busy", 32'(busy), 0);
        chk("s4_done", 32'(done), 0);
        chk("s4_send_data", 32'(send_data), 0);
        RST = 1'b0;
        req = 3'b111;
        push_exp(0, 8'hA1, 1'b1);
        wait_gnt(cyc);
        chk("s4_next_gnt", 32'(gnt), 32'b001);
        req = '0;
        pulse_fin(3);
        repeat (3) @(posedge CLK);
        #1;

        // Scenario 6: requester 2 withdraws before it would have won
        do_reset();
        req_data = {8'h7E, 8'h5A, 8'h00};
        req      = 3'b010;
        push_exp(1, 8'h5A, 1'b1);
        push_exp(1, 8'h5A, 1'b1);
        wait_gnt(cyc);
        req = 3'b110;
        repeat (2) begin
            @(posedge CLK);
            #1;
        end
        req = 3'b010;
        pulse_fin(5);
        wait_gnt(cyc);
        chk("s6_second_gnt", 32'(gnt), 32'b010);
        req = '0;
        pulse_fin(4);
        repeat (6) @(posedge CLK);
        #1;

`ifdef UART_TX_ARB_LOCK_EN
        // Scenario 5: locked requester 1 keeps the transmitter for three bytes
        do_reset();
        req_data = {8'hCC, 8'hBB, 8'hAA};
        req      = 3'b010;
        lock     = 3'b010;
        push_exp(1, 8'hBB, 1'b1);
        push_exp(1, 8'hBB, 1'b1);
        push_exp(1, 8'hBB, 1'b1);
        push_exp(2, 8'hCC, 1'b1);
        wait_gnt(cyc);
        req = 3'b111;
        pulse_fin(4);
        wait_gnt(cyc);
        chk("s5_lock_gnt2", 32'(gnt), 32'b010);
        pulse_fin(4);
        wait_gnt(cyc);
        chk("s5_lock_gnt3", 32'(gnt), 32'b010);
        lock = '0;
        pulse_fin(4);
        wait_gnt(cyc);
        chk("s5_unlock_gnt", 32'(gnt), 32'b100);
        req = '0;
        pulse_fin(4);
        repeat (4) @(posedge CLK);
        #1;
`endif

        chk("queues_drained", 32'(gnt_q.size() + done_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
